// File: rtl/shift_exec_stage.sv
// rtl/shift_exec_stage.sv - two-stage RV32I shift execute stage with valid/ready handshake
// Holds the combinational 32-bit barrel shifter and the pipelined decode/execute wrapper.

module barrel_shifter_optimized (
   input  logic [31:0] data,
   input  logic [4:0]  shamt,
   input  logic        right,
   input  logic        arith,
   output logic [31:0] result
);
   // Left shifts reuse the right-shift network by bit-reversing in and out.
   function automatic logic [31:0] rev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   logic        fill;
   logic [31:0] stg [0:5];

   assign fill   = right & arith & data[31];
   assign stg[0] = right ? data : rev32(data);

   for (genvar i = 0; i < 5; i++) begin : g_stage
      assign stg[i+1] = shamt[i] ? {{(2**i){fill}}, stg[i][31:2**i]} : stg[i];
   end

   assign result = right ? stg[5] : rev32(stg[5]);
endmodule

module shift_exec_stage #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_funct3,
   input  logic [6:0]      in_funct7,
   input  logic            in_is_imm,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [4:0]      in_imm,
   input  logic [RD_W-1:0] in_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_res,
   output logic [RD_W-1:0] out_rd,
   output logic            out_illegal
);
   logic            dec_right;
   logic            dec_arith;
   logic            dec_illegal;
   logic [4:0]      dec_shamt;

   logic            s1_valid;
   logic [XLEN-1:0] s1_rs1;
   logic [4:0]      s1_shamt;
   logic            s1_right;
   logic            s1_arith;
   logic [RD_W-1:0] s1_rd;
   logic            s1_illegal;
   logic            s2_valid;

   logic            s1_adv;
   logic            s2_adv;
   logic [XLEN-1:0] shift_res;

   // RV32 shifts only look at the low five bits of rs2.
   logic unused_rs2;
   assign unused_rs2 = ^in_rs2[XLEN-1:5];

   always_comb begin
      dec_right   = 1'b0;
      dec_arith   = 1'b0;
      dec_illegal = 1'b0;
      case (in_funct3)
         3'b001: begin
            if (in_funct7 != 7'b0000000) dec_illegal = 1'b1;
         end
         3'b101: begin
            if (in_funct7 == 7'b0000000) begin
               dec_right = 1'b1;
            end else if (in_funct7 == 7'b0100000) begin
               dec_right = 1'b1;
               dec_arith = 1'b1;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   assign dec_shamt = in_is_imm ? in_imm : in_rs2[4:0];

   assign s2_adv    = !s2_valid | out_ready;
   assign s1_adv    = !s1_valid | s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_rs1     <= '0;
         s1_shamt   <= '0;
         s1_right   <= 1'b0;
         s1_arith   <= 1'b0;
         s1_rd      <= '0;
         s1_illegal <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_rs1     <= in_rs1;
            s1_shamt   <= dec_shamt;
            s1_right   <= dec_right;
            s1_arith   <= dec_arith;
            s1_rd      <= in_rd;
            s1_illegal <= dec_illegal;
         end
      end
   end

   barrel_shifter_optimized u_shifter (
      .data   (s1_rs1),
      .shamt  (s1_shamt),
      .right  (s1_right),
      .arith  (s1_arith),
      .result (shift_res)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid    <= 1'b0;
         out_res     <= '0;
         out_rd      <= '0;
         out_illegal <= 1'b0;
      end else if (flush) begin
         s2_valid <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_res     <= s1_illegal ? '0 : shift_res;
            out_rd      <= s1_rd;
            out_illegal <= s1_illegal;
         end
      end
   end
endmodule

// File: tb/tb_shift_exec_stage.sv
// tb/tb_shift_exec_stage.sv - randomized and directed bench for shift_exec_stage
// Reference model is a queue of in-flight results computed with plain SV shift operators.

module tb_shift_exec_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_funct3 = 3'b0;
   logic [6:0]  in_funct7 = 7'b0;
   logic        in_is_imm = 1'b0;
   logic [31:0] in_rs1 = 32'b0;
   logic [31:0] in_rs2 = 32'b0;
   logic [4:0]  in_imm = 5'b0;
   logic [4:0]  in_rd = 5'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_res;
   logic [4:0]  out_rd;
   logic        out_illegal;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        ill;
      int          t;
   } exp_t;
   exp_t q[$];

   shift_exec_stage #(.XLEN(32), .RD_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_is_imm(in_is_imm),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_rd(out_rd), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Returns {illegal, result} straight from the ISA definition.
   function automatic logic [32:0] ref_op(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic is_imm, input logic [31:0] rs1,
                                          input logic [31:0] rs2, input logic [4:0] imm);
      int sh;
      sh = is_imm ? int'(imm) : int'(rs2 % 32);
      if (f3 == 3'b001 && f7 == 7'd0)          return {1'b0, rs1 << sh};
      if (f3 == 3'b101 && f7 == 7'd0)          return {1'b0, rs1 >> sh};
      if (f3 == 3'b101 && f7 == 7'b0100000)    return {1'b0, 32'($signed(rs1) >>> sh)};
      return {1'b1, 32'd0};
   endfunction

   always @(negedge clk) begin
      logic exp_ov, exp_ir;
      logic [32:0] r;
      exp_t e;
      if (rst) begin
         q.delete();
      end else begin
         exp_ov = (q.size() > 0) && (q[0].t + 2 <= cyc);
         exp_ir = !(q.size() == 2 && !out_ready);
         chk("out_valid", 32'(out_valid), 32'(exp_ov));
         chk("in_ready", 32'(in_ready), 32'(exp_ir));
         if (exp_ov && out_valid) begin
            chk("out_res", out_res, q[0].res);
            chk("out_rd", 32'(out_rd), 32'(q[0].rd));
            chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
         end
         if (flush) begin
            q.delete();
         end else begin
            if (exp_ov && out_ready) void'(q.pop_front());
            if (in_valid && exp_ir) begin
               r     = ref_op(in_funct3, in_funct7, in_is_imm, in_rs1, in_rs2, in_imm);
               e.res = r[31:0];
               e.ill = r[32];
               e.rd  = in_rd;
               e.t   = cyc;
               q.push_back(e);
            end
         end
      end
      cyc++;
   end

   task automatic send(input logic [2:0] f3, input logic [6:0] f7, input logic is_imm,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [4:0] imm, input logic [4:0] rd);
      bit done;
      done      = 1'b0;
      in_funct3 = f3;
      in_funct7 = f7;
      in_is_imm = is_imm;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_imm    = imm;
      in_rd     = rd;
      in_valid  = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready && !flush) done = 1'b1;
      end
      if (!done) chk("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out(input string name, input logic [31:0] res,
                           input logic [4:0] rd, input logic ill);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            done = 1'b1;
            chk(name, out_res, res);
            chk({name, "_rd"}, 32'(out_rd), 32'(rd));
            chk({name, "_ill"}, 32'(out_illegal), 32'(ill));
         end
      end
      if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_res", out_res, 32'd0);
      chk("rst_out_rd", 32'(out_rd), 32'd0);
      chk("rst_out_illegal", 32'(out_illegal), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Directed single ops
      send(3'b101, 7'h00, 1'b0, 32'hA5A5A5A5, 32'd1, 5'd0, 5'd7);
      @(negedge clk);
      chk("latency_not_yet", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      wait_out("srl1", 32'h52D2D2D2, 5'd7, 1'b0);
      send(3'b101, 7'h20, 1'b1, 32'hA5A5A5A5, 32'd0, 5'd16, 5'd1);
      wait_out("srai16", 32'hFFFFA5A5, 5'd1, 1'b0);
      send(3'b001, 7'h00, 1'b1, 32'h00000001, 32'd0, 5'd31, 5'd2);
      wait_out("slli31", 32'h80000000, 5'd2, 1'b0);
      send(3'b101, 7'h20, 1'b1, 32'h80000001, 32'd0, 5'd31, 5'd3);
      wait_out("srai31", 32'hFFFFFFFF, 5'd3, 1'b0);
      send(3'b001, 7'h00, 1'b0, 32'h00000001, 32'h00000023, 5'd0, 5'd4);
      wait_out("sll_mask", 32'h00000008, 5'd4, 1'b0);
      send(3'b001, 7'h00, 1'b0, 32'h12345678, 32'hFFFFFFE0, 5'd0, 5'd5);
      wait_out("sll_zero", 32'h12345678, 5'd5, 1'b0);
      send(3'b010, 7'h00, 1'b0, 32'h12345678, 32'd3, 5'd0, 5'd6);
      wait_out("ill_f3", 32'h0, 5'd6, 1'b1);
      send(3'b101, 7'h01, 1'b0, 32'h12345678, 32'd3, 5'd0, 5'd8);
      wait_out("ill_f7", 32'h0, 5'd8, 1'b1);

      // Backpressure: four ops streamed while the sink stalls
      out_ready = 1'b0;
      fork
         begin
            for (int k = 0; k < 4; k++)
               send(3'b101, 7'h20, 1'b0, 32'h80000000 >> k, 32'(k + 1), 5'd0, 5'(10 + k));
         end
         begin
            repeat (4) @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (6) @(posedge clk);
      #1;

      // Flush with two ops in flight; the op presented during flush is dropped
      out_ready = 1'b0;
      send(3'b001, 7'h00, 1'b0, 32'h1, 32'd1, 5'd0, 5'd20);
      send(3'b001, 7'h00, 1'b0, 32'h1, 32'd2, 5'd0, 5'd21);
      flush    = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(3'b101, 7'h00, 1'b1, 32'hF0000000, 32'd0, 5'd4, 5'd22);
      wait_out("post_flush", 32'h0F000000, 5'd22, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [1:0] sel;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         sel       = 2'($urandom_range(0, 3));
         in_funct3 = (sel == 0) ? 3'($urandom) : (sel[0] ? 3'b101 : 3'b001);
         sel       = 2'($urandom_range(0, 3));
         in_funct7 = (sel == 0) ? 7'($urandom) : (sel[0] ? 7'h20 : 7'h00);
         in_is_imm = 1'($urandom);
         sel       = 2'($urandom_range(0, 3));
         in_rs1    = (sel == 0) ? 32'h80000000 : (sel == 1) ? 32'hFFFFFFFF : 32'($urandom);
         in_rs2    = 32'($urandom);
         in_imm    = 5'($urandom);
         in_rd     = 5'($urandom);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Asynchronous reset between edges with a result waiting
      out_ready = 1'b0;
      send(3'b001, 7'h00, 1'b0, 32'h3, 32'd4, 5'd0, 5'd9);
      repeat (2) @(posedge clk);
      #3;
      chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_out_res", out_res, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      send(3'b101, 7'h20, 1'b0, 32'h80000000, 32'd0, 5'd0, 5'd30);
      wait_out("post_rst_sra0", 32'h80000000, 5'd30, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, tests %0d", tests);
      $fatal(1);
   end
endmodule
